timekeeper: RTL and testbench
=============================

# timekeeper

Parametrised, single-clock-domain time-of-day counter. It counts hours, minutes and seconds up (clock/stopwatch) or down (countdown timer), accepts a validated parallel preset, and raises a sticky expiry flag. It replaces divided-clock counting with an internal prescaler that produces a one-cycle tick enable, so every register runs on `clk`. It feeds the binary LED display logic.

## Interface
- `CLK_DIV`, default 50_000_000: `clk` cycles per one-second tick; must be at least 2.
- `HOURS_MAX`, default 23: last hour value before wrap. Use 23 for time of day, up to 99 for stopwatch use.
- `HOUR_W`, default 5: hours width, at least clog2(HOURS_MAX+1).
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: 1 = prescaler advances; 0 = prescaler and fields hold.
- `down` in 1: 0 = count up, 1 = count down; sampled on each tick.
- `load` in 1: single-cycle preset strobe.
- `load_h` in HOUR_W, `load_m` in 6, `load_s` in 6: preset values.
- `hours` out HOUR_W, `minutes` out 6, `seconds` out 6: current time, registered.
- `tick` out 1: one-cycle pulse on the edge the fields advance (or would advance).
- `expired` out 1: sticky; set when a countdown reaches 00:00:00.
- `load_err` out 1: one-cycle pulse when a preset is rejected.

## Operation
- **Reset**: all fields are 0, the prescaler is 0, and `tick`, `expired` and `load_err` are 0. Reset applies immediately on `rst_n` low, regardless of `clk`.
- **Prescaler**
  - While `run`=1 it counts 0..CLK_DIV-1, then wraps.
  - The wrap cycle is a tick. `tick` registers high for exactly one cycle.
- **Up mode** (on each tick):
  - `seconds` 59→0 carries into minutes.
  - `minutes` 59→0 carries into hours.
  - `hours` HOURS_MAX→0.
  - Carries ripple in the same tick, so HOURS_MAX:59:59 → 00:00:00 in one edge.
- **Down mode** (on each tick):
  - `seconds` 0→59 borrows from minutes; `minutes` 0→59 borrows from hours.
  - 00:00:01 → 00:00:00 sets `expired` on the same edge.
  - At 00:00:00 the fields hold; no wrap to HOURS_MAX.
  - `tick` still pulses on every prescaler wrap.
- **Load**
  - A load is valid when `load_s`≤59, `load_m`≤59 and `load_h`≤HOURS_MAX.
  - Valid load: fields take the preset values, the prescaler clears to 0, and `expired` clears.
  - Invalid load: fields, prescaler and `expired` are unchanged, and `load_err`=1 for one cycle.
- **Simultaneous events**
  - Load coincident with a tick: a valid load wins and the tick's field update is discarded. `tick` still pulses.
  - Invalid load coincident with a tick: the tick update proceeds.
- **Up mode with `expired`=1**: counting resumes; `expired` stays set until a valid load or reset.
- **Changing `down` between ticks**: takes effect at the next tick only.

## Timing
- All outputs are registered; no combinational input→output path.
- From `run` rising with the prescaler at 0, the first tick occurs on the CLK_DIV-th rising edge. The field update and `tick` are visible after that edge.
- A load applied on edge N is visible on the outputs after edge N, with `load_err` in the same cycle. The next tick follows exactly CLK_DIV `run` cycles later.
- Deasserting `run` freezes the prescaler value. Resuming continues from that value, so partial seconds are preserved.
- Reset mid-count returns everything to the reset values at once. The first post-reset tick comes CLK_DIV cycles after `rst_n` rises with `run`=1.

## Structure
- Package `timekeeper_pkg` holds:
  - `SEC_MAX`=59, `MIN_MAX`=59, `MS_W`=6
  - a `count_dir_e` enum with values UP and DOWN
  - the field-validation function
- One sub-module, `tick_prescaler`:
  - parameter CLK_DIV; inputs `clk`, `rst_n`, `run`, `clear`; output `tick`
  - the counter width is derived with clog2.
- The top level contains only the field counters, the load/validate logic and the `expired` flag.

## Test plan
All scenarios use CLK_DIV=4 and HOURS_MAX=23 unless stated.
1. Reset, then `run`=1 → outputs 00:00:00 and flags 0 during reset; the first `tick` is on the 4th edge with `seconds`=1; after 60 ticks the time is 00:01:00.
2. Load 23:59:59, up mode, one tick → 00:00:00 in a single edge; `tick`=1; `expired`=0.
3. Load 00:01:00 with `down`=1, one tick → 00:00:59. Then load 00:00:01, one tick → 00:00:00 with `expired`=1; three more ticks → still 00:00:00, `expired`=1, `tick` pulses each time.
4. From 05:10:20, load 12:60:00 → `load_err`=1 for one cycle; time stays 05:10:20; tick cadence is unaffected. Then a valid load of 12:30:00 → `expired` cleared.
5. Valid load of 01:02:03 on the same edge as a tick → outputs 01:02:03, not 01:02:04; the next tick is 4 cycles later.
6. Drop `run` with the prescaler at 2 for 10 cycles → no tick and the fields hold; after `run` returns, the next tick comes 2 cycles later. Assert `rst_n` low between clock edges → outputs 0 before the next `clk` edge.

Source files
------------

// File: rtl/timekeeper_pkg.sv
// Shared constants, count direction type and preset validation for the timekeeper.
// Field widths here are common to the interface, the top level and the bench.
package timekeeper_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int MS_W    = 6;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } count_dir_e;

    // A preset is accepted only if every field is within its legal range.
    function automatic logic fields_valid(input int unsigned h,
                                          input int unsigned m,
                                          input int unsigned s,
                                          input int unsigned h_max);
        return (s <= SEC_MAX) && (m <= MIN_MAX) && (h <= h_max);
    endfunction

endpackage

// File: rtl/timekeeper_if.sv
// Control/preset inputs and time/flag outputs of the timekeeper, bundled as one port.
// There is no valid/ready handshake: load is a single-cycle strobe sampled on every clk edge.
import timekeeper_pkg::*;

interface timekeeper_if #(
    parameter int HOUR_W = 5
);
    logic              run;
    logic              down;
    logic              load;
    logic [HOUR_W-1:0] load_h;
    logic [MS_W-1:0]   load_m;
    logic [MS_W-1:0]   load_s;
    logic [HOUR_W-1:0] hours;
    logic [MS_W-1:0]   minutes;
    logic [MS_W-1:0]   seconds;
    logic              tick;
    logic              expired;
    logic              load_err;

    modport master (
        output run, down, load, load_h, load_m, load_s,
        input  hours, minutes, seconds, tick, expired, load_err
    );

    modport slave (
        input  run, down, load, load_h, load_m, load_s,
        output hours, minutes, seconds, tick, expired, load_err
    );
endinterface

// File: rtl/timekeeper_tick_prescaler.sv
// Free-running divider that flags the clk edge on which one second elapses.
// tick is combinational so the field counters can act on that same edge.
module tick_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/timekeeper.sv
// Hours/minutes/seconds counter, up or down, with validated preset and sticky expiry.
// Every register runs on clk; the prescaler supplies a one-cycle advance enable.
import timekeeper_pkg::*;

module timekeeper #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int HOURS_MAX = 23,
    parameter int HOUR_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    timekeeper_if.slave bus
);
    localparam logic [HOUR_W-1:0] H_TOP = HOUR_W'(HOURS_MAX);
    localparam logic [MS_W-1:0]   S_TOP = MS_W'(SEC_MAX);
    localparam logic [MS_W-1:0]   M_TOP = MS_W'(MIN_MAX);

    logic [HOUR_W-1:0] r_hours;
    logic [MS_W-1:0]   r_minutes;
    logic [MS_W-1:0]   r_seconds;
    logic              r_tick;
    logic              r_expired;
    logic              r_load_err;

    logic       w_tick;
    logic       w_fields_ok;
    logic       w_load_ok;
    logic       w_zero;
    logic       w_one;
    count_dir_e w_dir;

    assign w_fields_ok = fields_valid(32'(bus.load_h), 32'(bus.load_m),
                                      32'(bus.load_s), HOURS_MAX);
    assign w_load_ok   = bus.load && w_fields_ok;
    assign w_dir       = count_dir_e'(bus.down);
    assign w_zero      = (r_hours == '0) && (r_minutes == '0) && (r_seconds == '0);
    assign w_one       = (r_hours == '0) && (r_minutes == '0) && (r_seconds == MS_W'(1));

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (bus.run),
        .clear (w_load_ok),
        .tick  (w_tick)
    );

    // A valid preset overrides a coincident tick; tick itself still pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hours    <= '0;
            r_minutes  <= '0;
            r_seconds  <= '0;
            r_tick     <= 1'b0;
            r_expired  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tick     <= w_tick;
            r_load_err <= bus.load && !w_fields_ok;
            if (w_load_ok) begin
                r_hours   <= bus.load_h;
                r_minutes <= bus.load_m;
                r_seconds <= bus.load_s;
                r_expired <= 1'b0;
            end else if (w_tick) begin
                if (w_dir == UP) begin
                    if (r_seconds == S_TOP) begin
                        r_seconds <= '0;
                        if (r_minutes == M_TOP) begin
                            r_minutes <= '0;
                            r_hours   <= (r_hours == H_TOP) ? '0 : r_hours + HOUR_W'(1);
                        end else begin
                            r_minutes <= r_minutes + MS_W'(1);
                        end
                    end else begin
                        r_seconds <= r_seconds + MS_W'(1);
                    end
                end else if (!w_zero) begin
                    if (r_seconds == '0) begin
                        r_seconds <= S_TOP;
                        if (r_minutes == '0) begin
                            r_minutes <= M_TOP;
                            r_hours   <= r_hours - HOUR_W'(1);
                        end else begin
                            r_minutes <= r_minutes - MS_W'(1);
                        end
                    end else begin
                        r_seconds <= r_seconds - MS_W'(1);
                    end
                    if (w_one) begin
                        r_expired <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.hours    = r_hours;
    assign bus.minutes  = r_minutes;
    assign bus.seconds  = r_seconds;
    assign bus.tick     = r_tick;
    assign bus.expired  = r_expired;
    assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_timekeeper.sv
// Bench for timekeeper: directed scenarios plus random stimulus, checked every cycle
// against a model that keeps time as a single count of seconds.
module tb_timekeeper;
    import timekeeper_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int HOURS_MAX = 23;
    localparam int HOUR_W    = 5;
    localparam int DAY       = (HOURS_MAX + 1) * 3600;
    localparam int W         = HOUR_W + 2 * MS_W + 3;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_assert;
    int   n_fail;

    timekeeper_if #(.HOUR_W(HOUR_W)) bus ();

    timekeeper #(
        .CLK_DIV   (CLK_DIV),
        .HOURS_MAX (HOURS_MAX),
        .HOUR_W    (HOUR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int   m_t;
    int   m_phase;
    logic m_tick;
    logic m_exp;
    logic m_lerr;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] snap();
        return {HOUR_W'(m_t / 3600), MS_W'((m_t / 60) % 60), MS_W'(m_t % 60),
                m_tick, m_exp, m_lerr};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_phase = 0; m_tick = 0; m_exp = 0; m_lerr = 0;
            exp_q.delete();
        end else begin
            logic fire;
            logic ok;
            fire = bus.run && (m_phase == CLK_DIV - 1);
            ok   = (int'(bus.load_s) <= 59) && (int'(bus.load_m) <= 59) &&
                   (int'(bus.load_h) <= HOURS_MAX);
            m_tick = fire;
            m_lerr = bus.load && !ok;
            if (bus.load && ok) begin
                m_t     = int'(bus.load_h) * 3600 + int'(bus.load_m) * 60 + int'(bus.load_s);
                m_phase = 0;
                m_exp   = 0;
            end else begin
                if (bus.run) m_phase = (m_phase + 1) % CLK_DIV;
                if (fire) begin
                    if (!bus.down) begin
                        m_t = (m_t + 1) % DAY;
                    end else if (m_t > 0) begin
                        m_t = m_t - 1;
                        if (m_t == 0) m_exp = 1;
                    end
                end
            end
        end
        exp_q.push_back(snap());
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] g;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {bus.hours, bus.minutes, bus.seconds, bus.tick, bus.expired, bus.load_err};
            if (chk_en) begin
                n_assert++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL model t=%0t: got %0d:%0d:%0d tick=%b exp=%b lerr=%b, want %0d:%0d:%0d tick=%b exp=%b lerr=%b",
                             $time, g[W-1 -: HOUR_W], g[2*MS_W+2 -: MS_W], g[MS_W+2 -: MS_W],
                             g[2], g[1], g[0], e[W-1 -: HOUR_W], e[2*MS_W+2 -: MS_W],
                             e[MS_W+2 -: MS_W], e[2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        bus.load_h = HOUR_W'(h);
        bus.load_m = MS_W'(m);
        bus.load_s = MS_W'(s);
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic check_out(input string name, input int h, input int m, input int s,
                             input logic tk, input logic ex, input logic le);
        n_assert++;
        if (int'(bus.hours) != h || int'(bus.minutes) != m || int'(bus.seconds) != s ||
            bus.tick !== tk || bus.expired !== ex || bus.load_err !== le) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d:%0d tick=%b exp=%b lerr=%b, want %0d:%0d:%0d tick=%b exp=%b lerr=%b",
                     name, bus.hours, bus.minutes, bus.seconds, bus.tick, bus.expired,
                     bus.load_err, h, m, s, tk, ex, le);
        end
    endtask

    // ---------------- stimulus ----------------
    int bnd_h[4] = '{23, 0, 0, 23};
    int bnd_m[4] = '{59, 0, 1, 59};
    int bnd_s[4] = '{58, 2, 0, 59};

    initial begin
        n_assert = 0; n_fail = 0; chk_en = 1'b0;
        bus.run = 1'b0; bus.down = 1'b0; bus.load = 1'b0;
        bus.load_h = '0; bus.load_m = '0; bus.load_s = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #7 chk_en = 1'b1;
        cyc(2);
        check_out("reset_state", 0, 0, 0, 0, 0, 0);

        // 1: first tick on the 4th edge, 60 ticks reach one minute
        rst_n = 1'b1; bus.run = 1'b1;
        cyc(3);
        check_out("pre_first_tick", 0, 0, 0, 0, 0, 0);
        cyc(1);
        check_out("first_tick", 0, 0, 1, 1, 0, 0);
        cyc(CLK_DIV * 59);
        check_out("sixty_ticks", 0, 1, 0, 1, 0, 0);

        // 2: full rollover in one edge
        do_load(23, 59, 59);
        check_out("load_235959", 23, 59, 59, 0, 0, 0);
        cyc(4);
        check_out("rollover", 0, 0, 0, 1, 0, 0);

        // 3: countdown, borrow, expiry and hold at zero
        bus.down = 1'b1;
        do_load(0, 1, 0);
        cyc(4);
        check_out("borrow", 0, 0, 59, 1, 0, 0);
        do_load(0, 0, 1);
        cyc(4);
        check_out("expire", 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(4);
            check_out("hold_zero", 0, 0, 0, 1, 1, 0);
        end

        // 4: rejected preset does not disturb time or cadence
        bus.down = 1'b0;
        do_load(5, 10, 20);
        check_out("load_051020", 5, 10, 20, 0, 0, 0);
        cyc(1);
        do_load(12, 60, 0);
        check_out("load_err", 5, 10, 20, 0, 0, 1);
        cyc(1);
        check_out("load_err_pulse", 5, 10, 20, 0, 0, 0);
        cyc(1);
        check_out("cadence_kept", 5, 10, 21, 1, 0, 0);
        do_load(12, 30, 0);
        check_out("load_123000", 12, 30, 0, 0, 0, 0);

        // 5: valid load coincident with a tick wins
        cyc(3);
        do_load(1, 2, 3);
        check_out("load_on_tick", 1, 2, 3, 1, 0, 0);
        cyc(3);
        check_out("after_load_tick", 1, 2, 3, 0, 0, 0);
        cyc(1);
        check_out("next_tick", 1, 2, 4, 1, 0, 0);

        // 6: pause preserves the partial second; async reset
        cyc(2);
        bus.run = 1'b0;
        cyc(10);
        check_out("paused", 1, 2, 4, 0, 0, 0);
        bus.run = 1'b1;
        cyc(1);
        check_out("resume_1", 1, 2, 4, 0, 0, 0);
        cyc(1);
        check_out("resume_2", 1, 2, 5, 1, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_out("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);
        check_out("post_reset_tick", 0, 0, 1, 1, 0, 0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            bus.run  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) bus.down = ~bus.down;
            bus.load = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                bus.load = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    int k;
                    k = $urandom_range(0, 3);
                    bus.load_h = HOUR_W'(bnd_h[k]);
                    bus.load_m = MS_W'(bnd_m[k]);
                    bus.load_s = MS_W'(bnd_s[k]);
                end else begin
                    bus.load_h = HOUR_W'($urandom_range(0, 31));
                    bus.load_m = MS_W'($urandom_range(0, 63));
                    bus.load_s = MS_W'($urandom_range(0, 63));
                end
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
